// File: rtl/game_flow_ctrl.sv
// Game round flow control: menu/run/pause/end sequencing, round timer with
// setting adjust, fall-speed levels and the periodic player-controls swap window.
module game_flow_ctrl #(
  parameter int NPLAYER     = 2,
  parameter int TW          = 16,
  parameter int TICK_DIV    = 50000000,
  parameter int UNIT        = 60,
  parameter int SET_DEF     = 3,
  parameter int SET_MAX     = 15,
  parameter int SWAP_PERIOD = 256,
  parameter int SWAP_LEN    = 5,
  parameter int SPD1_AT     = 256,
  parameter int SPD2_AT     = 48
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 space,
  input  logic                 pause,
  input  logic                 restart,
  input  logic [NPLAYER-1:0]   fail,
  input  logic [5*NPLAYER-1:0] ctrl_in,
  output logic [5*NPLAYER-1:0] ctrl_out,
  output logic [2:0]           state,
  output logic                 start,
  output logic                 ifstart,
  output logic                 help,
  output logic [TW-1:0]        timer,
  output logic [3:0]           setting,
  output logic                 swap,
  output logic [1:0]           speed
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_END   = 3'd3,
    S_MAIN  = 3'd4
  } state_t;

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (SWAP_LEN > 0) ? $clog2(SWAP_LEN + 1) : 1;

  state_t               cur_st, nxt_st;
  logic [DW-1:0]        presc;
  logic [CW-1:0]        swap_cnt;
  logic                 tick, any_up, any_dn, swap_hit;
  logic [TW-1:0]        timer_load, timer_dec;
  logic [5*NPLAYER-1:0] ctrl_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur_st <= S_MAIN;
    else       cur_st <= nxt_st;
  end

  // END before PAUSE so a loss in the same cycle as a pause request ends the round
  always_comb begin
    nxt_st = cur_st;
    if (restart) nxt_st = S_MAIN;
    else begin
      case (cur_st)
        S_MAIN:  if (space) nxt_st = S_IDLE;
        S_IDLE:  if (space && timer != '0) nxt_st = S_RUN;
        S_RUN:   if ((|fail) || timer == '0) nxt_st = S_END;
                 else if (pause) nxt_st = S_PAUSE;
        S_PAUSE: if (space) nxt_st = S_RUN;
        default: ;
      endcase
    end
  end

  always_comb begin
    state   = cur_st;
    start   = (cur_st == S_RUN);
    ifstart = (cur_st == S_RUN) || (cur_st == S_PAUSE) || (cur_st == S_END);
    help    = (cur_st == S_MAIN) || (cur_st == S_PAUSE);
  end

  // In the menu only up/down pass through; swap is always clear there
  always_comb begin
    any_up   = 1'b0;
    any_dn   = 1'b0;
    ctrl_nxt = '0;
    for (int unsigned i = 0; i < NPLAYER; i++) begin
      any_up = any_up | ctrl_in[5*i];
      any_dn = any_dn | ctrl_in[5*i+1];
      if (start)
        ctrl_nxt[5*i +: 5] = swap ? ctrl_in[5*((i+1)%NPLAYER) +: 5] : ctrl_in[5*i +: 5];
      else if (!ifstart)
        ctrl_nxt[5*i +: 5] = {3'b000, ctrl_in[5*i+1], ctrl_in[5*i]};
    end
  end

  assign timer_load = TW'(32'(setting) * 32'(UNIT));
  assign timer_dec  = timer - TW'(1);
  assign tick       = (cur_st == S_RUN) && (presc == DW'(TICK_DIV - 1));
  assign swap_hit   = (timer != '0) && (timer_dec != '0) &&
                      ((timer_dec & TW'(SWAP_PERIOD - 1)) == '0);
  assign swap       = (swap_cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      setting  <= 4'(SET_DEF);
      timer    <= TW'(SET_DEF * UNIT);
      presc    <= '0;
      swap_cnt <= '0;
      speed    <= '0;
      ctrl_out <= '0;
    end else if (restart) begin
      timer    <= timer_load;
      presc    <= '0;
      swap_cnt <= '0;
      speed    <= '0;
      ctrl_out <= '0;
    end else begin
      ctrl_out <= ctrl_nxt;
      if (!ifstart) begin
        if (any_up) begin
          if (setting < 4'(SET_MAX)) setting <= setting + 4'd1;
        end else if (any_dn && setting > 4'd1) begin
          setting <= setting - 4'd1;
        end
        timer    <= timer_load;
        presc    <= '0;
        swap_cnt <= '0;
        speed    <= '0;
      end else begin
        if (cur_st == S_RUN) presc <= tick ? '0 : presc + DW'(1);
        if (tick && timer != '0) timer <= timer_dec;
        if (tick) begin
          if (swap_hit)  swap_cnt <= CW'(SWAP_LEN);
          else if (swap) swap_cnt <= swap_cnt - CW'(1);
        end
        if (timer <= TW'(SPD2_AT))      speed <= 2'd2;
        else if (timer <= TW'(SPD1_AT)) speed <= 2'd1;
        else                            speed <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: vector table, directed multi-cycle scenarios and
// random stimulus checked every cycle against a behavioural model.
module tb_game_flow_ctrl;
  localparam int NP = 2, TW = 16, TDIV = 2, UNIT = 60, SET_DEF = 3, SET_MAX = 15;
  localparam int SWP_PER = 256, SWP_LEN = 5, SPD1 = 256, SPD2 = 48;

  logic clk = 1'b0;
  logic rstn, space, pause, restart;
  logic [NP-1:0]   fail;
  logic [5*NP-1:0] ctrl_in, ctrl_out;
  logic [2:0]      state;
  logic            start, ifstart, help, swap;
  logic [TW-1:0]   timer;
  logic [3:0]      setting;
  logic [1:0]      speed;

  game_flow_ctrl #(.NPLAYER(NP), .TW(TW), .TICK_DIV(TDIV), .UNIT(UNIT), .SET_DEF(SET_DEF),
    .SET_MAX(SET_MAX), .SWAP_PERIOD(SWP_PER), .SWAP_LEN(SWP_LEN), .SPD1_AT(SPD1),
    .SPD2_AT(SPD2)) dut (
    .clk(clk), .rstn(rstn), .space(space), .pause(pause), .restart(restart), .fail(fail),
    .ctrl_in(ctrl_in), .ctrl_out(ctrl_out), .state(state), .start(start), .ifstart(ifstart),
    .help(help), .timer(timer), .setting(setting), .swap(swap), .speed(speed));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // model: phase 4=main 0=idle 1=run 2=pause 3=end, seconds left, sub-second count
  int m_st, m_set, m_tmr, m_div, m_swp, m_spd;
  logic [5*NP-1:0] m_out;

  typedef struct {
    logic sp, pa, rs;
    logic [NP-1:0] fl;
    logic [5*NP-1:0] ci;
    int st, set, tmr;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 4; m_set = SET_DEF; m_tmr = SET_DEF * UNIT; m_div = 0;
    m_swp = 0; m_spd = 0; m_out = '0;
  endtask

  task automatic model_step();
    int nst, nset, ntmr, ndiv, nswp, nspd, after, src;
    logic [5*NP-1:0] nout;
    logic [4:0] bits;
    bit menu, tick, anyup, anydn;
    menu = (m_st == 4 || m_st == 0);
    nout = '0;
    if (restart) begin
      nst = 4; nset = m_set; ntmr = (m_set * UNIT) % (1 << TW);
      ndiv = 0; nswp = 0; nspd = 0;
    end else begin
      anyup = 0; anydn = 0;
      for (int p = 0; p < NP; p++) begin
        anyup |= ctrl_in[5*p];
        anydn |= ctrl_in[5*p+1];
      end
      nset = m_set;
      if (menu && anyup)      nset = (m_set < SET_MAX) ? m_set + 1 : m_set;
      else if (menu && anydn) nset = (m_set > 1) ? m_set - 1 : m_set;
      tick = (m_st == 1) && (m_div == TDIV - 1);
      ndiv = (m_st == 1) ? (m_div + 1) % TDIV : (menu ? 0 : m_div);
      if (menu)                   ntmr = (m_set * UNIT) % (1 << TW);
      else if (tick && m_tmr > 0) ntmr = m_tmr - 1;
      else                        ntmr = m_tmr;
      if (menu) nswp = 0;
      else if (tick) begin
        after = (m_tmr > 0) ? m_tmr - 1 : 0;
        if (after != 0 && after % SWP_PER == 0) nswp = SWP_LEN;
        else nswp = (m_swp > 0) ? m_swp - 1 : 0;
      end else nswp = m_swp;
      nspd = menu ? 0 : (m_tmr <= SPD2 ? 2 : (m_tmr <= SPD1 ? 1 : 0));
      for (int p = 0; p < NP; p++) begin
        src = (m_swp != 0) ? (p + 1) % NP : p;
        bits = ctrl_in[5*src +: 5];
        if (m_st == 1)  nout[5*p +: 5] = bits;
        else if (menu)  nout[5*p +: 5] = bits & 5'b00011;
      end
      nst = m_st;
      case (m_st)
        4: if (space) nst = 0;
        0: if (space && m_tmr != 0) nst = 1;
        1: if ((|fail) || m_tmr == 0) nst = 3; else if (pause) nst = 2;
        2: if (space) nst = 1;
        default: ;
      endcase
    end
    m_st = nst; m_set = nset; m_tmr = ntmr; m_div = ndiv;
    m_swp = nswp; m_spd = nspd; m_out = nout;
  endtask

  task automatic compare_model();
    chk("state", state, m_st);
    chk("start", start, m_st == 1);
    chk("ifstart", ifstart, m_st >= 1 && m_st <= 3);
    chk("help", help, m_st == 4 || m_st == 2);
    chk("timer", timer, m_tmr);
    chk("setting", setting, m_set);
    chk("swap", swap, m_swp != 0);
    chk("speed", speed, m_spd);
    chk("ctrl_out", ctrl_out, m_out);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_in();
    space = 0; pause = 0; restart = 0; fail = '0; ctrl_in = '0;
  endtask

  task automatic press(input int kind, input int n);
    // kind: 0 up (player 0), 1 down (player 1), 2 space
    for (int k = 0; k < n; k++) begin
      idle_in();
      if (kind == 0) ctrl_in = 10'h001;
      else if (kind == 1) ctrl_in = 10'h040;
      else space = 1;
      step();
    end
    idle_in();
  endtask

  initial begin
    int n, cnt;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 10'h000, 0, 3, 180};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 10'h001, 0, 4, 180};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 0, 4, 240};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 10'h040, 0, 3, 240};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 0, 3, 180};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'b00, 10'h000, 1, 3, 180};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'b10, 10'h000, 3, 3, 180};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 3, 3, 180};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 10'h000, 3, 3, 180};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'b00, 10'h000, 4, 3, 180};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 2'b00, 10'h000, 4, 3, 180};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 10'h001, 4, 3, 180};

    idle_in();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    model_reset();
    compare_model();
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      space = tbl[i].sp; pause = tbl[i].pa; restart = tbl[i].rs;
      fail = tbl[i].fl; ctrl_in = tbl[i].ci;
      step();
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
      chk($sformatf("vec%0d_setting", i), setting, tbl[i].set);
      chk($sformatf("vec%0d_timer", i), timer, tbl[i].tmr);
    end
    idle_in();

    // setting saturation in the menu
    press(0, 20);
    chk("sat_max", setting, 15);
    press(1, 2);
    step();
    chk("set_13", setting, 13);
    chk("timer_780", timer, 780);

    // swap window at 256 s, then pause holding timer, swap and prescaler
    press(1, 8);
    step();
    chk("timer_300", timer, 300);
    press(2, 2);
    chk("run_start", start, 1);
    ctrl_in = 10'h001;
    step();
    chk("route_noswap", ctrl_out, 10'h001);
    idle_in();
    n = 0;
    while (m_tmr != 256 && n < 300) begin step(); n++; end
    chk("reach_256", timer, 256);
    chk("swap_on", swap, 1);
    ctrl_in = 10'h001; pause = 1;
    step();
    idle_in();
    chk("route_swap", ctrl_out, 10'h020);
    chk("paused", state, 2);
    for (int k = 0; k < 100; k++) step();
    chk("pause_timer", timer, 256);
    chk("pause_swap", swap, 1);
    press(2, 1);
    chk("resume", state, 1);
    step();
    chk("presc_resume", timer, 255);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin step(); if (swap) cnt++; end
    chk("swap_len", cnt, 7);

    // restart at 40 s with speed 2
    n = 0;
    while (m_tmr != 40 && n < 1200) begin step(); n++; end
    chk("reach_40", timer, 40);
    chk("speed_2", speed, 2);
    restart = 1; ctrl_in = 10'h3FF;
    step();
    idle_in();
    chk("rst_state", state, 4);
    chk("rst_speed", speed, 0);
    chk("rst_timer", timer, 300);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_setting", setting, 5);

    // timer running out ends the round
    press(1, 4);
    step();
    press(2, 2);
    n = 0;
    while (m_st != 3 && n < 400) begin step(); n++; end
    chk("timeout_end", state, 3);
    chk("timeout_timer", timer, 0);
    chk("timeout_speed", speed, 2);
    restart = 1;
    step();
    idle_in();

    for (int k = 0; k < 4000; k++) begin
      space   = ($urandom_range(0, 9) == 0);
      pause   = ($urandom_range(0, 29) == 0);
      restart = ($urandom_range(0, 199) == 0);
      fail    = '0;
      for (int p = 0; p < NP; p++) fail[p] = ($urandom_range(0, 99) == 0);
      ctrl_in = '0;
      for (int b = 0; b < 5*NP; b++) ctrl_in[b] = ($urandom_range(0, 4) == 0);
      step();
    end
    idle_in();

    // asynchronous reset mid-cycle
    #3 rstn = 1'b0;
    #1;
    model_reset();
    compare_model();
    @(negedge clk) rstn = 1'b1;
    for (int k = 0; k < 5; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
